// File: rtl/writeback_regfile_pkg.sv
// Shared pipeline definitions: load-size encodings, register-file geometry
// and a small extension helper used by the load formatter.
package pipeline_pkg;

  localparam int DW        = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

  // 2'b11 is not named; consumers treat it as a full word.
  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10
  } load_size_e;

  // Sign- or zero-extend a sub-word value held in the low bits of v.
  // When is_half is 0 only v[7:0] is meaningful.
  function automatic logic [DW-1:0] ext_sub(input logic [15:0] v,
                                            input logic        is_half,
                                            input logic        sgn);
    logic [DW-1:0] r;
    if (is_half) begin
      r = {{(DW-16){sgn & v[15]}}, v};
    end else begin
      r = {{(DW-8){sgn & v[7]}}, v[7:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// Bus between the MEM/WB register / decode stage and the writeback register
// file. master = pipeline side driving writeback and read indices,
// slave = the register file.
interface writeback_regfile_if #(
  parameter int CNT_W = 32
);
  import pipeline_pkg::*;

  // writeback side
  logic [DW-1:0]        outE_M;
  logic [DW-1:0]        DataoutM;
  logic [REG_IDX_W-1:0] RegEscr1E_M;
  logic                 RegWrite_M;
  logic                 MemToReg_M;
  logic [1:0]           LoadSize_M;
  logic                 LoadSigned_M;

  // decode read ports
  logic [REG_IDX_W-1:0] RegLect1;
  logic [REG_IDX_W-1:0] RegLect2;
  logic [DW-1:0]        DatoLect1;
  logic [DW-1:0]        DatoLect2;

  // status
  logic [DW-1:0]        WbData;
  logic                 WbActive;
  logic [CNT_W-1:0]     RetireCnt;

  modport master (
    output outE_M, DataoutM, RegEscr1E_M, RegWrite_M, MemToReg_M,
           LoadSize_M, LoadSigned_M, RegLect1, RegLect2,
    input  DatoLect1, DatoLect2, WbData, WbActive, RetireCnt
  );

  modport slave (
    input  outE_M, DataoutM, RegEscr1E_M, RegWrite_M, MemToReg_M,
           LoadSize_M, LoadSigned_M, RegLect1, RegLect2,
    output DatoLect1, DatoLect2, WbData, WbActive, RetireCnt
  );

endinterface

// File: rtl/writeback_regfile_load_formatter.sv
// Combinational load formatter: picks the addressed byte/halfword lane out of
// a little-endian memory word and extends it to full width. Kept standalone
// so the store-side alignment check can reuse it.
module load_formatter
  import pipeline_pkg::*;
(
  input  logic [DW-1:0] data_i,
  input  logic [1:0]    offset_i,
  input  logic [1:0]    size_i,
  input  logic          signed_i,
  output logic [DW-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane selection: byte lane 0 is bits [7:0]; halfword ignores offset bit 0.
  always_comb begin
    byte_lane = data_i[{offset_i, 3'b000} +: 8];
    half_lane = offset_i[1] ? data_i[31:16] : data_i[15:0];
  end

  // Size decode and extension; the unnamed encoding 2'b11 behaves as a word.
  always_comb begin
    data_o = data_i;
    case (size_i)
      LS_BYTE: data_o = ext_sub({8'h00, byte_lane}, 1'b0, signed_i);
      LS_HALF: data_o = ext_sub(half_lane, 1'b1, signed_i);
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage + architectural register file. Formats the writeback value,
// commits it one edge later, serves two combinational read ports with
// same-cycle bypass, and counts committed writes for debug.
module writeback_regfile
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  writeback_regfile_if.slave bus
);

  localparam int NPORT = 2;

  logic [DW-1:0]        regs_q [NREG];
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;

  logic [DW-1:0]        fmt_data;
  logic [DW-1:0]        wb_data;
  logic                 wb_active;
  logic [REG_IDX_W-1:0] wr_idx;

  logic [REG_IDX_W-1:0] rd_idx  [NPORT];
  logic [DW-1:0]        rd_data [NPORT];

  load_formatter u_fmt (
    .data_i   (bus.DataoutM),
    .offset_i (bus.outE_M[1:0]),
    .size_i   (bus.LoadSize_M),
    .signed_i (bus.LoadSigned_M),
    .data_o   (fmt_data)
  );

  // Writeback value select and commit qualification; index 0 never commits.
  always_comb begin
    wr_idx    = bus.RegEscr1E_M;
    wb_data   = bus.MemToReg_M ? fmt_data : bus.outE_M;
    wb_active = bus.RegWrite_M && (wr_idx != ZERO_REG);
  end

  // Register array; entry 0 is never written so it stays zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_active) begin
      regs_q[wr_idx] <= wb_data;
    end
  end

  // Retired-write counter next state; wraps naturally at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (wb_active) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Retired-write counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_idx[0] = bus.RegLect1;
  assign rd_idx[1] = bus.RegLect2;

  // Read ports: index 0 reads zero, a pending write to the same index is
  // forwarded, otherwise the stored value is returned.
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_rd
    always_comb begin
      rd_data[gi] = regs_q[rd_idx[gi]];
      if (rd_idx[gi] == ZERO_REG) begin
        rd_data[gi] = '0;
      end else if (wb_active && (rd_idx[gi] == wr_idx)) begin
        rd_data[gi] = wb_data;
      end
    end
  end

  assign bus.DatoLect1 = rd_data[0];
  assign bus.DatoLect2 = rd_data[1];
  assign bus.WbData    = wb_data;
  assign bus.WbActive  = wb_active;
  assign bus.RetireCnt = cnt_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile. Expected values are pushed to a
// scoreboard queue when stimulus is applied and popped when the matching
// DUT output is sampled. A second instance with a 4-bit counter covers wrap.
module tb_writeback_regfile;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];

  writeback_regfile_if #(.CNT_W(32)) bm ();
  writeback_regfile_if #(.CNT_W(4))  bs ();

  writeback_regfile #(.CNT_W(32)) u_main (
    .clk   (clk),
    .reset (reset),
    .bus   (bm.slave)
  );

  writeback_regfile #(.CNT_W(4)) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (bs.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the sequence is short; anything this long is a hang.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "timeout");
  end

  // RegWrite_M must never be X outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      n_checks++;
      assert (!$isunknown(bm.RegWrite_M)) else begin
        n_fail++;
        $error("FAIL regwrite_x observed=%b required=known", bm.RegWrite_M);
      end
    end
  end

  task automatic push(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_item_t it;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%h required=queued_expectation", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h required=%h", it.tag, obs, it.exp);
      end
      $display("check %-14s observed=%h expected=%h", it.tag, obs, it.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [31:0] dout, input logic [1:0] off,
                          input logic [1:0] size, input logic sgn);
    bm.MemToReg_M   = 1'b1;
    bm.DataoutM     = dout;
    bm.outE_M       = {30'h0, off};
    bm.LoadSize_M   = size;
    bm.LoadSigned_M = sgn;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;

    bm.outE_M = '0; bm.DataoutM = '0; bm.RegEscr1E_M = '0;
    bm.RegWrite_M = 1'b0; bm.MemToReg_M = 1'b0; bm.LoadSize_M = 2'b10;
    bm.LoadSigned_M = 1'b0; bm.RegLect1 = '0; bm.RegLect2 = '0;
    bs.outE_M = '0; bs.DataoutM = '0; bs.RegEscr1E_M = '0;
    bs.RegWrite_M = 1'b0; bs.MemToReg_M = 1'b0; bs.LoadSize_M = 2'b10;
    bs.LoadSigned_M = 1'b0; bs.RegLect1 = '0; bs.RegLect2 = '0;

    repeat (2) tick();
    reset = 1'b0;
    #1;

    // Reset state: every index reads zero on both ports, counter zero.
    for (int i = 0; i < 32; i++) begin
      bm.RegLect1 = 5'(i);
      bm.RegLect2 = 5'(31 - i);
      push($sformatf("rst_rd1_%0d", i), 32'h0);
      push($sformatf("rst_rd2_%0d", 31 - i), 32'h0);
      #1;
      check(bm.DatoLect1);
      check(bm.DatoLect2);
    end
    push("rst_cnt", 32'h0);
    check(bm.RetireCnt);

    // ALU writeback to r5 with same-cycle bypass, then stored.
    tick();
    bm.RegWrite_M = 1'b1; bm.MemToReg_M = 1'b0; bm.RegEscr1E_M = 5'd5;
    bm.outE_M = 32'h1234_5678; bm.RegLect1 = 5'd5; bm.RegLect2 = 5'd0;
    push("r5_bypass", 32'h1234_5678);
    push("r5_active", 32'h1);
    push("r5_stored", 32'h1234_5678);
    push("r5_cnt", 32'd1);
    #1;
    check(bm.DatoLect1);
    check({31'h0, bm.WbActive});
    tick();
    bm.RegWrite_M = 1'b0;
    #1;
    check(bm.DatoLect1);
    check(bm.RetireCnt);

    // Load formatting, no commit.
    set_load(32'h80FF_7F01, 2'd2, 2'b00, 1'b1); push("ld_b2_s", 32'hFFFF_FFFF); #1; check(bm.WbData);
    set_load(32'h80FF_7F01, 2'd3, 2'b00, 1'b1); push("ld_b3_s", 32'hFFFF_FF80); #1; check(bm.WbData);
    set_load(32'h80FF_7F01, 2'd3, 2'b00, 1'b0); push("ld_b3_u", 32'h0000_0080); #1; check(bm.WbData);
    set_load(32'h80FF_7F01, 2'd2, 2'b01, 1'b1); push("ld_h2_s", 32'hFFFF_80FF); #1; check(bm.WbData);
    set_load(32'h80FF_7F01, 2'd3, 2'b01, 1'b1); push("ld_h3_s", 32'hFFFF_80FF); #1; check(bm.WbData);
    set_load(32'h80FF_7F01, 2'd0, 2'b01, 1'b1); push("ld_h0_s", 32'h0000_7F01); #1; check(bm.WbData);
    set_load(32'h80FF_7F01, 2'd1, 2'b00, 1'b1); push("ld_b1_s", 32'h0000_007F); #1; check(bm.WbData);
    set_load(32'h80FF_7F01, 2'd0, 2'b00, 1'b1); push("ld_b0_s", 32'h0000_0001); #1; check(bm.WbData);
    set_load(32'h80FF_7F01, 2'd1, 2'b10, 1'b1); push("ld_word", 32'h80FF_7F01); #1; check(bm.WbData);
    set_load(32'h80FF_7F01, 2'd2, 2'b11, 1'b0); push("ld_w11", 32'h80FF_7F01); #1; check(bm.WbData);
    push("ld_inactive", 32'h0); check({31'h0, bm.WbActive});

    // Commit a formatted load to r3.
    tick();
    set_load(32'h80FF_7F01, 2'd3, 2'b00, 1'b1);
    bm.RegWrite_M = 1'b1; bm.RegEscr1E_M = 5'd3; bm.RegLect1 = 5'd3;
    tick();
    bm.RegWrite_M = 1'b0; bm.MemToReg_M = 1'b0;
    push("r3_load", 32'hFFFF_FF80);
    push("r3_cnt", 32'd2);
    #1;
    check(bm.DatoLect1);
    check(bm.RetireCnt);

    // Write to r0 is discarded, reads of 0 stay 0 even under "bypass".
    bm.RegWrite_M = 1'b1; bm.RegEscr1E_M = 5'd0; bm.outE_M = 32'hDEAD_BEEF;
    bm.RegLect1 = 5'd0; bm.RegLect2 = 5'd0;
    push("r0_active", 32'h0);
    push("r0_rd1_pre", 32'h0);
    push("r0_rd2_pre", 32'h0);
    push("r0_rd1_post", 32'h0);
    push("r0_rd2_post", 32'h0);
    push("r0_cnt", 32'd2);
    #1;
    check({31'h0, bm.WbActive});
    check(bm.DatoLect1);
    check(bm.DatoLect2);
    tick();
    check(bm.DatoLect1);
    check(bm.DatoLect2);
    check(bm.RetireCnt);

    // Back-to-back writes to r7 with both ports reading it.
    bm.RegEscr1E_M = 5'd7; bm.outE_M = 32'hA;
    bm.RegLect1 = 5'd7; bm.RegLect2 = 5'd7;
    push("r7_a_rd1", 32'hA);
    push("r7_a_rd2", 32'hA);
    #1;
    check(bm.DatoLect1);
    check(bm.DatoLect2);
    tick();
    bm.outE_M = 32'hB;
    push("r7_b_rd1", 32'hB);
    push("r7_b_rd2", 32'hB);
    #1;
    check(bm.DatoLect1);
    check(bm.DatoLect2);
    tick();
    bm.RegWrite_M = 1'b0;
    push("r7_st_rd1", 32'hB);
    push("r7_st_rd2", 32'hB);
    push("r7_cnt", 32'd4);
    #1;
    check(bm.DatoLect1);
    check(bm.DatoLect2);
    check(bm.RetireCnt);

    // One port bypasses while the other reads a different stored register.
    bm.RegWrite_M = 1'b1; bm.RegEscr1E_M = 5'd7; bm.outE_M = 32'hC;
    bm.RegLect1 = 5'd7; bm.RegLect2 = 5'd5;
    push("mix_rd1", 32'hC);
    push("mix_rd2", 32'h1234_5678);
    #1;
    check(bm.DatoLect1);
    check(bm.DatoLect2);
    bm.RegWrite_M = 1'b0;
    push("mix_nobyp", 32'hB);
    #1;
    check(bm.DatoLect1);

    // Counter wrap on the 4-bit instance.
    tick();
    bs.RegWrite_M = 1'b1; bs.RegEscr1E_M = 5'd1; bs.RegLect1 = 5'd1;
    for (int k = 0; k < 15; k++) begin
      bs.outE_M = 32'(k);
      tick();
    end
    bs.RegWrite_M = 1'b0;
    push("wrap_cnt15", 32'd15);
    push("wrap_r1", 32'd14);
    #1;
    check({28'h0, bs.RetireCnt});
    check(bs.DatoLect1);
    bs.RegWrite_M = 1'b1; bs.outE_M = 32'd99;
    tick();
    bs.RegWrite_M = 1'b0;
    push("wrap_cnt0", 32'd0);
    #1;
    check({28'h0, bs.RetireCnt});

    // Reset arrives while a write to r9 is set up: the write is lost.
    bm.RegWrite_M = 1'b1; bm.MemToReg_M = 1'b0; bm.RegEscr1E_M = 5'd9;
    bm.outE_M = 32'h55AA_33CC; bm.RegLect1 = 5'd9; bm.RegLect2 = 5'd5;
    #1;
    reset = 1'b1;
    tick();
    bm.RegWrite_M = 1'b0;
    reset = 1'b0;
    push("rstw_r9", 32'h0);
    push("rstw_r5", 32'h0);
    push("rstw_cnt", 32'h0);
    #1;
    check(bm.DatoLect1);
    check(bm.DatoLect2);
    check(bm.RetireCnt);

    // First edge after deassertion commits normally.
    bm.RegWrite_M = 1'b1;
    tick();
    bm.RegWrite_M = 1'b0;
    push("post_rst_r9", 32'h55AA_33CC);
    push("post_rst_cnt", 32'd1);
    #1;
    check(bm.DatoLect1);
    check(bm.RetireCnt);

    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover observed=%0d required=0", sb.size());
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
